// File: rtl/cfi_pkg.sv
// Shared types and defaults for the CFI violation alert handler.
// The record layout is {pc, seq, state}, packed MSB-first.
package cfi_pkg;

    localparam int unsigned CFI_DEPTH_DEFAULT     = 4;
    localparam int unsigned CFI_THRESHOLD_DEFAULT = 8;

    typedef struct packed {
        logic [63:0] pc;
        logic [7:0]  seq;
        logic [1:0]  state;
    } cfi_record_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ALERT    = 2'd1,
        ST_LOCKDOWN = 2'd2
    } cfi_state_e;

endpackage

// File: rtl/cfi_record_fifo.sv
// First-word-fall-through FIFO for violation records.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module cfi_record_fifo
    import cfi_pkg::*;
#(
    parameter int unsigned DEPTH = CFI_DEPTH_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic        pop_i,
    input  cfi_record_t data_i,
    output cfi_record_t data_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    cfi_record_t     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count == (AW + 1)'(DEPTH));
    assign empty_o = (count == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Head is forced to zero when empty so the output is defined out of reset.
    assign data_o = empty_o ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cfi_alert_handler.sv
// Collects CFI violation pulses into a record FIFO, counts them, and
// escalates IDLE -> ALERT -> LOCKDOWN with irq/halt outputs.
module cfi_alert_handler
    import cfi_pkg::*;
#(
    parameter int unsigned DEPTH     = CFI_DEPTH_DEFAULT,
    parameter int unsigned THRESHOLD = CFI_THRESHOLD_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        det_valid_i,
    input  logic [1:0]  det_state_i,
    input  logic [63:0] det_pc_i,
    output logic        rec_valid_o,
    input  logic        rec_ready_i,
    output cfi_record_t rec_o,
    output logic        ovf_o,
    output logic [15:0] viol_cnt_o,
    output logic        irq_o,
    input  logic        irq_clr_i,
    output logic        halt_req_o,
    input  logic        unlock_i
);

    cfi_state_e  state_q;
    cfi_state_e  state_d;
    logic [7:0]  seq_q;
    logic [15:0] cnt_base;
    logic [15:0] cnt_next;
    logic        unlocking;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        drop;
    cfi_record_t push_rec;

    assign rec_valid_o = !fifo_empty;
    assign pop         = rec_valid_o && rec_ready_i;
    assign drop        = det_valid_i && fifo_full && !pop;
    assign unlocking   = (state_q == ST_LOCKDOWN) && unlock_i;

    // Unlocking restarts the count from zero, so a detection in the same cycle counts as the first.
    assign cnt_base = unlocking ? 16'd0 : viol_cnt_o;
    assign cnt_next = !det_valid_i          ? cnt_base :
                      (cnt_base == 16'hFFFF) ? cnt_base : cnt_base + 16'd1;

    assign push_rec = '{pc: det_pc_i, seq: seq_q, state: det_state_i};

    cfi_record_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (det_valid_i),
        .pop_i   (pop),
        .data_i  (push_rec),
        .data_o  (rec_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_ALERT: begin
                if (det_valid_i) begin
                    state_d = (cnt_next >= 16'(THRESHOLD)) ? ST_LOCKDOWN : ST_ALERT;
                end else if (state_q == ST_ALERT && irq_clr_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKDOWN: begin
                if (unlock_i) begin
                    state_d = det_valid_i ? ST_ALERT : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            irq_o      <= 1'b0;
            halt_req_o <= 1'b0;
            seq_q      <= '0;
            viol_cnt_o <= '0;
            ovf_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_o      <= (state_d != ST_IDLE);
            halt_req_o <= (state_d == ST_LOCKDOWN);
            viol_cnt_o <= cnt_next;
            if (det_valid_i) begin
                seq_q <= seq_q + 8'd1;
            end
            // A drop in the unlock cycle is a fresh overflow and wins over the clear.
            if (drop) begin
                ovf_o <= 1'b1;
            end else if (unlocking) begin
                ovf_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cfi_alert_handler.md
CFI_ALERT_HANDLER -- requirements
Module: cfi_alert_handler

Interface
REQ-001 SHALL have parameter DEPTH, default 4: violation record FIFO entries, power of two, minimum 2.
REQ-002 SHALL have parameter THRESHOLD, default 8: violation count that triggers lockdown, range 1..65535.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port det_valid_i, input, 1: one-cycle violation pulse from the CFI commit monitor (bit 0 of its detection output).
REQ-006 SHALL have port det_state_i, input, 2: monitor state bits (bits 3:2 of its detection output), captured into the record.
REQ-007 SHALL have port det_pc_i, input, 64: PC of commit port 0 in the cycle det_valid_i is high.
REQ-008 SHALL have port rec_valid_o, output, 1: a violation record is presented.
REQ-009 SHALL have port rec_ready_i, input, 1: consumer accepts the record.
REQ-010 SHALL have port rec_o, output, cfi_record_t: {pc 64, seq 8, state 2}.
REQ-011 SHALL have port ovf_o, output, 1: sticky flag, a record was dropped.
REQ-012 SHALL have port viol_cnt_o, output, 16: saturating violation count.
REQ-013 SHALL have port irq_o, output, 1: level interrupt request.
REQ-014 SHALL have port irq_clr_i, input, 1: interrupt acknowledge.
REQ-015 SHALL have port halt_req_o, output, 1: core halt request, level.
REQ-016 SHALL have port unlock_i, input, 1: leave lockdown.

Function
REQ-017 SHALL push {det_pc_i, seq, det_state_i} into the FIFO on det_valid_i when FIFO not full, or when full with a pop in the same cycle.
REQ-018 SHALL drop the record when full without a same-cycle pop, and set ovf_o to 1 from the next cycle until reset or unlock_i.
REQ-019 SHALL present the FIFO head first-word-fall-through: rec_valid_o high the cycle after the push, transfer when rec_valid_o && rec_ready_i.
REQ-020 SHALL hold rec_o stable while rec_valid_o && !rec_ready_i.
REQ-021 SHALL increment the 8-bit seq after every det_valid_i, dropped or not, wrapping 255->0, so drops appear as gaps.
REQ-022 SHALL increment viol_cnt_o by 1 per det_valid_i, saturating at 0xFFFF.
REQ-023 SHALL implement FSM IDLE / ALERT / LOCKDOWN; irq_o = (ALERT or LOCKDOWN), halt_req_o = LOCKDOWN, both registered.
REQ-024 IDLE -> ALERT on det_valid_i.
REQ-025 ALERT -> IDLE on irq_clr_i without det_valid_i in the same cycle; with det_valid_i the FSM SHALL stay in ALERT.
REQ-026 IDLE or ALERT -> LOCKDOWN when det_valid_i and incremented count >= THRESHOLD; takes priority over REQ-024/025.
REQ-027 LOCKDOWN SHALL ignore irq_clr_i; detections still recorded and counted.
REQ-028 LOCKDOWN -> IDLE on unlock_i; viol_cnt_o and ovf_o cleared the same edge; FIFO contents and seq preserved; det_valid_i in that cycle is recorded, counted from 0 (count becomes 1), and the FSM SHALL go to ALERT instead.
REQ-029 unlock_i outside LOCKDOWN SHALL have no effect.

Reset
REQ-030 On rst_ni low, immediately: FSM IDLE, FIFO empty, rec_valid_o 0, seq 0, viol_cnt_o 0, ovf_o 0, irq_o 0, halt_req_o 0; rec_o contents don't-care, driven 0.
REQ-031 Reset mid-transfer SHALL discard all pending records; no record is emitted after release until a new det_valid_i.

Structure
REQ-032 cfi_pkg SHALL hold cfi_record_t, the FSM state enum, and default DEPTH/THRESHOLD constants.
REQ-033 FIFO SHALL be a separate sub-module cfi_record_fifo (parameterised DEPTH, full/empty, push/pop, FWFT); FSM and counters in cfi_alert_handler.

Verification
REQ-034 Single pulse, pc=0x8000_0040, rec_ready_i=1 -> next cycle rec_valid_o=1, pc 0x8000_0040, seq 0; irq_o=1; irq_clr_i -> irq_o=0 the following cycle.
REQ-035 rec_ready_i=0, 6 pulses, DEPTH=4 -> 4 records seq 0..3 held, ovf_o=1, viol_cnt_o=6; releasing ready drains seq 0,1,2,3 in order.
REQ-036 THRESHOLD=8, 8 pulses -> halt_req_o=1 after 8th; irq_clr_i ignored; unlock_i -> IDLE, viol_cnt_o=0, ovf_o=0, halt_req_o=0.
REQ-037 det_valid_i and irq_clr_i same cycle in ALERT -> irq_o stays 1; full FIFO with push+pop same cycle -> no drop, ovf_o stays 0.
REQ-038 Assert rst_ni low with 3 records queued and LOCKDOWN active -> all outputs 0 asynchronously; after release, no rec_valid_o until a new pulse, whose seq is 0.
